// File: rtl/mipi_csi_frame_controller.sv
// -----------------------------------------------------------------------------
// mipi_csi_frame_controller
//
// Frame-level sequencer in front of the CSI-2 RX packet decoder. It spots
// Frame Start / Frame End short packets in the lane-aligned word stream and
// only lets the decoder see data while a frame is open. It also counts lines
// and frames, checks line length consistency, and keeps sticky error flags
// for the downstream bridge.
//
// All registers update on the falling edge of clk_i, the same edge the packet
// decoder uses.
//
// Handshake: data_valid_i qualifies data_i for one clock. There is no
// back-pressure; every word presented with data_valid_i=1 is consumed.
// dec_data_valid_o is data_valid_i passed through only while a frame is open.
//
// Ports:
//   clk_i               MIPI byte clock (falling-edge registers)
//   reset_n_i           asynchronous active-low reset
//   enable_i            capture enable
//   err_clear_i         one-cycle pulse, clears sticky errors (a set wins)
//   data_valid_i        lane-aligner valid
//   data_i[31:0]        lane-aligned word, byte 0 = lane 0
//   dec_output_valid_i  decoder output_valid (high for one long packet)
//   dec_packet_length_i decoder packet length in bytes
//   expected_lines_i    lines per frame, 0 disables the line-count check
//   dec_data_valid_o    gated valid into the decoder
//   frame_valid_o       high between accepted FS and FE
//   line_valid_o        registered decoder output_valid, qualified by frame
//   frame_start_o       one-cycle pulse on accepted FS
//   frame_end_o         one-cycle pulse on FE
//   line_count_o        completed lines in the current / last frame
//   frame_count_o       completed frames, wraps
//   err_seq_o           sticky: FS inside a frame or FE outside a frame
//   err_line_count_o    sticky: line count at FE differs from expected
//   err_line_length_o   sticky: line length mismatch or not LANES-aligned
// -----------------------------------------------------------------------------
module mipi_csi_frame_controller #(
  parameter logic [7:0] SYNC_BYTE      = 8'hB8,
  parameter logic [7:0] DT_FRAME_START = 8'h00,
  parameter logic [7:0] DT_FRAME_END   = 8'h01,
  parameter int         LANES          = 4
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        enable_i,
  input  logic        err_clear_i,
  input  logic        data_valid_i,
  input  logic [31:0] data_i,
  input  logic        dec_output_valid_i,
  input  logic [15:0] dec_packet_length_i,
  input  logic [15:0] expected_lines_i,
  output logic        dec_data_valid_o,
  output logic        frame_valid_o,
  output logic        line_valid_o,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic [15:0] line_count_o,
  output logic [15:0] frame_count_o,
  output logic        err_seq_o,
  output logic        err_line_count_o,
  output logic        err_line_length_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_FS  = 2'd1,
    IN_FRAME = 2'd2
  } state_t;

  state_t      state;
  // Only lane 0 of the previous word takes part in header detection, so only
  // that byte is kept. It reads as zero after any invalid cycle.
  logic [7:0]  prev_byte;
  logic        dov_q;
  logic [15:0] ref_length;

  logic        in_frame;
  logic        hdr_fs;
  logic        hdr_fe;
  logic        line_end;
  logic        line_start;
  logic        len_unaligned;
  logic [15:0] lines_next;
  logic        seq_set;
  logic        lc_set;
  logic        ll_set;
  logic        unused_data;

  assign unused_data = ^data_i[31:8];

  assign in_frame = (state == IN_FRAME);

  // Header detection runs on the raw stream, never on the gated valid.
  assign hdr_fs = data_valid_i && (prev_byte == SYNC_BYTE) && (data_i[7:0] == DT_FRAME_START);
  assign hdr_fe = data_valid_i && (prev_byte == SYNC_BYTE) && (data_i[7:0] == DT_FRAME_END);

  assign dec_data_valid_o = data_valid_i & in_frame;
  assign line_valid_o     = dov_q & frame_valid_o;

  // A line ends when the registered output_valid is about to fall.
  assign line_end   = in_frame && dov_q && !dec_output_valid_i;
  assign line_start = dec_output_valid_i && !dov_q;

  // Line count including a line that ends this very cycle; saturates.
  assign lines_next = (line_end && (line_count_o != 16'hFFFF)) ? line_count_o + 16'd1
                                                                : line_count_o;

  assign len_unaligned = (dec_packet_length_i % 16'(LANES)) != 16'd0;

  always_comb begin
    seq_set = 1'b0;
    lc_set  = 1'b0;
    ll_set  = 1'b0;
    if (state == WAIT_FS && enable_i && hdr_fe) seq_set = 1'b1;
    if (in_frame && hdr_fs) seq_set = 1'b1;
    if (in_frame && hdr_fe && (expected_lines_i != 16'd0) && (lines_next != expected_lines_i))
      lc_set = 1'b1;
    if (line_start && (((ref_length != 16'd0) && (dec_packet_length_i != ref_length)) || len_unaligned))
      ll_set = 1'b1;
  end

  always_ff @(negedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state             <= IDLE;
      prev_byte         <= 8'd0;
      dov_q             <= 1'b0;
      ref_length        <= 16'd0;
      frame_valid_o     <= 1'b0;
      frame_start_o     <= 1'b0;
      frame_end_o       <= 1'b0;
      line_count_o      <= 16'd0;
      frame_count_o     <= 16'd0;
      err_seq_o         <= 1'b0;
      err_line_count_o  <= 1'b0;
      err_line_length_o <= 1'b0;
    end else begin
      prev_byte     <= data_valid_i ? data_i[7:0] : 8'd0;
      dov_q         <= dec_output_valid_i;
      frame_start_o <= 1'b0;
      frame_end_o   <= 1'b0;
      line_count_o  <= lines_next;
      if (line_start && (ref_length == 16'd0)) ref_length <= dec_packet_length_i;

      err_seq_o         <= (err_seq_o         & ~err_clear_i) | seq_set;
      err_line_count_o  <= (err_line_count_o  & ~err_clear_i) | lc_set;
      err_line_length_o <= (err_line_length_o & ~err_clear_i) | ll_set;

      case (state)
        IDLE: begin
          if (enable_i) state <= WAIT_FS;
        end
        WAIT_FS: begin
          if (!enable_i) begin
            state <= IDLE;
          end else if (hdr_fs) begin
            state         <= IN_FRAME;
            frame_valid_o <= 1'b1;
            frame_start_o <= 1'b1;
            line_count_o  <= 16'd0;
            ref_length    <= 16'd0;
          end
        end
        IN_FRAME: begin
          // enable_i is ignored here so a frame is never truncated.
          if (hdr_fe) begin
            frame_end_o   <= 1'b1;
            frame_valid_o <= 1'b0;
            frame_count_o <= frame_count_o + 16'd1;
            state         <= enable_i ? WAIT_FS : IDLE;
          end else if (hdr_fs) begin
            // Restart the frame in place.
            frame_start_o <= 1'b1;
            line_count_o  <= 16'd0;
            ref_length    <= 16'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_csi_frame_controller.sv
// -----------------------------------------------------------------------------
// tb_mipi_csi_frame_controller
//
// Directed frames plus randomized frames against a behavioural model of the
// frame rules. Inputs change just after the falling (active) edge; the model
// advances on the falling edge from the same inputs; a compare process checks
// every output on the rising edge.
// -----------------------------------------------------------------------------
module tb_mipi_csi_frame_controller;

  localparam logic [7:0] SYNC  = 8'hB8;
  localparam logic [7:0] DT_FS = 8'h00;
  localparam logic [7:0] DT_FE = 8'h01;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        err_clear = 1'b0;
  logic        dv = 1'b0;
  logic [31:0] data = 32'd0;
  logic        dov = 1'b0;
  logic [15:0] plen = 16'd0;
  logic [15:0] exp_lines = 16'd0;

  logic        dec_data_valid_o, frame_valid_o, line_valid_o, frame_start_o, frame_end_o;
  logic [15:0] line_count_o, frame_count_o;
  logic        err_seq_o, err_line_count_o, err_line_length_o;

  always #5 clk = ~clk;

  mipi_csi_frame_controller dut (
    .clk_i               (clk),
    .reset_n_i           (reset_n),
    .enable_i            (enable),
    .err_clear_i         (err_clear),
    .data_valid_i        (dv),
    .data_i              (data),
    .dec_output_valid_i  (dov),
    .dec_packet_length_i (plen),
    .expected_lines_i    (exp_lines),
    .dec_data_valid_o    (dec_data_valid_o),
    .frame_valid_o       (frame_valid_o),
    .line_valid_o        (line_valid_o),
    .frame_start_o       (frame_start_o),
    .frame_end_o         (frame_end_o),
    .line_count_o        (line_count_o),
    .frame_count_o       (frame_count_o),
    .err_seq_o           (err_seq_o),
    .err_line_count_o    (err_line_count_o),
    .err_line_length_o   (err_line_length_o)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int n_fs_seen = 0;
  int n_fe_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_prev;
  logic        m_dov_d;
  logic [15:0] m_ref;
  bit          m_armed;   // waiting for FS
  bit          m_in;      // frame open
  logic        e_fv, e_lv, e_fs, e_fe, e_seq, e_lcnt, e_llen;
  logic [15:0] e_lc, e_fc;

  function automatic void model_reset();
    m_prev = '0; m_dov_d = 0; m_ref = '0; m_armed = 0; m_in = 0;
    e_fv = 0; e_lv = 0; e_fs = 0; e_fe = 0; e_seq = 0; e_lcnt = 0; e_llen = 0;
    e_lc = '0; e_fc = '0;
  endfunction

  function automatic void model_update();
    bit is_fs, is_fe, lend, rise;
    bit s_seq = 0, s_lc = 0, s_ll = 0;
    is_fs = dv && m_prev[7:0] == SYNC && data[7:0] == DT_FS;
    is_fe = dv && m_prev[7:0] == SYNC && data[7:0] == DT_FE;
    lend  = m_in && m_dov_d && !dov;
    rise  = dov && !m_dov_d;
    e_fs = 0;
    e_fe = 0;
    if (lend && e_lc != 16'hFFFF) e_lc = e_lc + 1;
    if (rise) begin
      if (m_ref == 0) m_ref = plen;
      else if (plen != m_ref) s_ll = 1;
      if (plen % 4 != 0) s_ll = 1;
    end
    if (m_in) begin
      if (is_fe) begin
        e_fe = 1;
        e_fc = e_fc + 1;
        if (exp_lines != 0 && e_lc != exp_lines) s_lc = 1;
        m_in = 0;
        m_armed = enable;
      end else if (is_fs) begin
        s_seq = 1; e_lc = 0; m_ref = 0; e_fs = 1;
      end
    end else if (m_armed) begin
      if (!enable) m_armed = 0;
      else if (is_fs) begin
        m_in = 1; m_armed = 0; e_lc = 0; m_ref = 0; e_fs = 1;
      end else if (is_fe) s_seq = 1;
    end else if (enable) begin
      m_armed = 1;
    end
    e_seq  = (e_seq  & ~err_clear) | s_seq;
    e_lcnt = (e_lcnt & ~err_clear) | s_lc;
    e_llen = (e_llen & ~err_clear) | s_ll;
    e_fv    = m_in;
    e_lv    = dov & m_in;
    m_dov_d = dov;
    m_prev  = dv ? data : 32'd0;
  endfunction

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    if (chk_en) begin
      check("dec_data_valid", dec_data_valid_o, dv & m_in);
      check("frame_valid",    frame_valid_o,    e_fv);
      check("line_valid",     line_valid_o,     e_lv);
      check("frame_start",    frame_start_o,    e_fs);
      check("frame_end",      frame_end_o,      e_fe);
      check("line_count",     line_count_o,     e_lc);
      check("frame_count",    frame_count_o,    e_fc);
      check("err_seq",        err_seq_o,        e_seq);
      check("err_line_count", err_line_count_o, e_lcnt);
      check("err_line_len",   err_line_length_o, e_llen);
      if (frame_start_o) n_fs_seen++;
      if (frame_end_o)   n_fe_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    if (reset_n) model_update();
    else model_reset();
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[7:0] == SYNC) w[7:0] = 8'h5A;
    return w;
  endfunction

  task automatic idle_cycles(input int n);
    dv = 0;
    repeat (n) begin
      err_clear = ($urandom_range(0, 7) == 0);
      step();
    end
    err_clear = 0;
  endtask

  task automatic word(input logic [7:0] b0);
    logic [31:0] w;
    w = rand_word();
    dv = 1;
    data = {w[31:8], b0};
    step();
  endtask

  task automatic send_fs();
    dov = 0;
    word(SYNC);
    word(DT_FS);
    dv = 0;
  endtask

  // hold_dov keeps a running line alive into the sync word so it ends on
  // the FE header cycle itself.
  task automatic send_fe(input bit hold_dov);
    if (!hold_dov) dov = 0;
    word(SYNC);
    dov = 0;
    word(DT_FE);
    dv = 0;
  endtask

  task automatic send_line(input logic [15:0] len, input int gap);
    plen = len;
    dov = 1;
    repeat ($urandom_range(2, 5)) begin
      dv = ($urandom_range(0, 3) != 0);
      data = rand_word();
      step();
    end
    dov = 0;
    repeat (gap) begin
      dv = $urandom_range(0, 1);
      data = rand_word();
      step();
    end
    dv = 0;
  endtask

  task automatic run_frame(input int lines, input logic [15:0] len);
    send_fs();
    for (int i = 0; i < lines; i++) send_line(len, 1);
    send_fe(0);
    idle_cycles(2);
  endtask

  task automatic pulse_clear();
    err_clear = 1;
    step();
    err_clear = 0;
  endtask

  function automatic logic [15:0] pick_len();
    case ($urandom_range(0, 5))
      0: return 16'h04FC;
      1: return 16'h0501;
      default: return 16'h0500;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    step();
    step();
    // Reset state.
    check("rst dec_data_valid", dec_data_valid_o, 0);
    check("rst frame_valid",    frame_valid_o, 0);
    check("rst line_valid",     line_valid_o, 0);
    check("rst frame_start",    frame_start_o, 0);
    check("rst frame_end",      frame_end_o, 0);
    check("rst line_count",     line_count_o, 0);
    check("rst frame_count",    frame_count_o, 0);
    check("rst err_seq",        err_seq_o, 0);
    check("rst err_line_count", err_line_count_o, 0);
    check("rst err_line_len",   err_line_length_o, 0);
    chk_en = 1;
    reset_n = 1;
    step();

    // Basic frame: 3 lines of 0x500, 3 expected.
    enable = 1;
    exp_lines = 16'd3;
    step();
    n_fs_seen = 0;
    n_fe_seen = 0;
    send_fs();
    check("t1 frame_valid after FS", frame_valid_o, 1);
    for (int i = 0; i < 3; i++) send_line(16'h0500, 1);
    send_fe(0);
    check("t1 frame_valid after FE", frame_valid_o, 0);
    idle_cycles(2);
    check("t1 fs pulses", n_fs_seen, 1);
    check("t1 fe pulses", n_fe_seen, 1);
    check("t1 line_count", line_count_o, 3);
    check("t1 frame_count", frame_count_o, 1);
    check("t1 errors", {err_seq_o, err_line_count_o, err_line_length_o}, 0);

    // Line count mismatch, then clear.
    exp_lines = 16'd4;
    run_frame(3, 16'h0500);
    check("t2 err_line_count", err_line_count_o, 1);
    check("t2 frame_count", frame_count_o, 2);
    pulse_clear();
    check("t2 err_line_count cleared", err_line_count_o, 0);

    // Line length mismatch and unaligned length.
    exp_lines = 16'd0;
    send_fs();
    send_line(16'h0500, 1);
    send_line(16'h04FC, 1);
    send_fe(0);
    check("t3 err_len mismatch", err_line_length_o, 1);
    pulse_clear();
    check("t3 err_len cleared", err_line_length_o, 0);
    run_frame(1, 16'h0501);
    check("t3 err_len unaligned", err_line_length_o, 1);
    pulse_clear();

    // FS inside a frame restarts it.
    exp_lines = 16'd2;
    n_fs_seen = 0;
    send_fs();
    send_line(16'h0500, 1);
    send_fs();
    send_line(16'h0500, 1);
    send_line(16'h0500, 1);
    send_fe(0);
    idle_cycles(1);
    check("t4 err_seq", err_seq_o, 1);
    check("t4 fs pulses", n_fs_seen, 2);
    check("t4 line_count", line_count_o, 2);
    check("t4 frame_count", frame_count_o, 5);
    check("t4 err_line_count", err_line_count_o, 0);
    pulse_clear();
    check("t4 err_seq cleared", err_seq_o, 0);
    send_fe(0);
    step();
    check("t4 stray FE err_seq", err_seq_o, 1);
    check("t4 stray FE frame_count", frame_count_o, 5);
    pulse_clear();

    // Enable dropped mid-frame: frame completes, next FS ignored.
    send_fs();
    send_line(16'h0500, 1);
    enable = 0;
    send_line(16'h0500, 1);
    send_fe(0);
    idle_cycles(2);
    check("t5 frame_count", frame_count_o, 6);
    send_fs();
    check("t5 frame_valid after ignored FS", frame_valid_o, 0);
    dv = 1;
    data = rand_word();
    #1;
    check("t5 gated valid", dec_data_valid_o, 0);
    step();
    dv = 0;

    // Line ending on the FE header cycle counts toward the check.
    enable = 1;
    exp_lines = 16'd1;
    step();
    send_fs();
    send_line(16'h0500, 0);
    send_fe(1);
    idle_cycles(1);
    check("t6 same-cycle line_count", line_count_o, 1);
    check("t6 same-cycle err_line_count", err_line_count_o, 0);
    check("t6 frame_count", frame_count_o, 7);

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      int nl;
      bit hold;
      if ($urandom_range(0, 9) == 0) enable = 0;
      else enable = 1;
      idle_cycles($urandom_range(1, 3));
      if ($urandom_range(0, 5) == 0) send_fe(0);
      nl = $urandom_range(1, 4);
      case ($urandom_range(0, 2))
        0: exp_lines = 16'd0;
        1: exp_lines = 16'(nl);
        default: exp_lines = 16'(nl + 1);
      endcase
      send_fs();
      for (int i = 0; i < nl; i++) begin
        if ($urandom_range(0, 9) == 0) send_fs();
        if ($urandom_range(0, 9) == 0) enable = 0;
        send_line(pick_len(), (i == nl - 1) ? $urandom_range(0, 1) : $urandom_range(1, 3));
      end
      hold = (dov == 0) && ($urandom_range(0, 1) == 1);
      if (hold) dov = 1;
      send_fe(hold);
    end
    idle_cycles(2);

    // Asynchronous reset mid-line.
    enable = 1;
    err_clear = 0;
    step();
    send_fs();
    plen = 16'h0500;
    dov = 1;
    dv = 1;
    data = rand_word();
    step();
    step();
    #2;
    reset_n = 0;
    model_reset();
    #1;
    check("ar dec_data_valid", dec_data_valid_o, 0);
    check("ar frame_valid",    frame_valid_o, 0);
    check("ar line_valid",     line_valid_o, 0);
    check("ar line_count",     line_count_o, 0);
    check("ar frame_count",    frame_count_o, 0);
    check("ar errors", {err_seq_o, err_line_count_o, err_line_length_o}, 0);
    step();
    step();
    dov = 0;
    dv = 0;
    reset_n = 1;
    step();
    step();
    exp_lines = 16'd2;
    run_frame(2, 16'h0500);
    check("ar frame_count after frame", frame_count_o, 1);
    check("ar line_count after frame", line_count_o, 2);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, limit 2000000 reached");
    $fatal(1, "watchdog");
  end

endmodule
